// File: rtl/tpu_vec_pkg.sv
// Shared widths and counter sizing for the TPU vector stream blocks.
// Element counters must also represent the full-vector count, hence clog2(SIZE+1).
package tpu_vec_pkg;

  localparam int ELEM_W   = 4;
  localparam int VEC_SIZE = 16;

  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/vec_hold_slot.sv
// Output holding register: takes a vector plus element count on load, keeps it until drained.
// Latency: load -> out_valid next cycle. Backpressure: contents frozen while out_valid && !out_ready.
// slot_free tells the producer a load this cycle cannot overwrite an undelivered vector.
module vec_hold_slot
  import tpu_vec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         slot_free
);

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_to_vector.sv
// Deserializer: SIZE elements of DWIDTH bits -> one vector; PARTIAL_FLUSH_EN adds in_last early close.
// Latency: last element accept -> out_valid next cycle; sustains 1 element/clk with no inter-vector gap.
// Backpressure: a completed vector parks in the assembly register; in_ready drops until the slot frees.
module stream_to_vector
  import tpu_vec_pkg::*;
#(
  parameter int DWIDTH = ELEM_W,
  parameter int SIZE   = VEC_SIZE,
  parameter int CNT_W  = cnt_width(SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DWIDTH-1:0]      in_data,
`ifdef PARTIAL_FLUSH_EN
  input  logic                   in_last,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE*DWIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       out_count
);

  localparam int VW = SIZE * DWIDTH;

  logic [CNT_W-1:0] cnt, asm_cnt, cnt_inc, slot_cnt;
  logic [VW-1:0]    asm_q, asm_next;
  logic             asm_full;
  logic             accept, last_el, complete, slot_free, load;
  logic [VW+CNT_W-1:0] load_word, slot_word;

  assign in_ready = !rst && !asm_full;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt + CNT_W'(1);

`ifdef PARTIAL_FLUSH_EN
  assign last_el = (cnt == CNT_W'(SIZE - 1)) || in_last;
`else
  assign last_el = (cnt == CNT_W'(SIZE - 1));
`endif

  assign complete = accept && last_el;

  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < SIZE; k++) begin
      if (cnt == CNT_W'(k)) asm_next[k*DWIDTH +: DWIDTH] = in_data;
    end
  end

  // A parked vector always goes first; no element is accepted while it waits.
  assign load      = slot_free && (asm_full || complete);
  assign load_word = asm_full ? {asm_cnt, asm_q} : {cnt_inc, asm_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      asm_cnt  <= '0;
      asm_q    <= '0;
      asm_full <= 1'b0;
    end else if (asm_full) begin
      if (slot_free) begin
        asm_q    <= '0;
        asm_full <= 1'b0;
      end
    end else if (accept) begin
      if (complete) begin
        cnt <= '0;
        if (slot_free) begin
          asm_q <= '0;
        end else begin
          asm_q    <= asm_next;
          asm_cnt  <= cnt_inc;
          asm_full <= 1'b1;
        end
      end else begin
        cnt   <= cnt_inc;
        asm_q <= asm_next;
      end
    end
  end

  vec_hold_slot #(
    .W(VW + CNT_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (slot_word),
    .slot_free (slot_free)
  );

  assign out_data  = slot_word[VW-1:0];
  assign slot_cnt  = slot_word[VW +: CNT_W];
  assign out_count = out_valid ? slot_cnt : '0;

endmodule

// File: tb/tb_stream_to_vector.sv
// Directed + randomized bench for stream_to_vector (DWIDTH=4, SIZE=16).
module tb_stream_to_vector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
`ifdef PARTIAL_FLUSH_EN
  logic        in_last;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_count;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  stream_to_vector #(.DWIDTH(4), .SIZE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef PARTIAL_FLUSH_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  logic [63:0] exp_vec, pattern, prev_data, cur;
  logic [63:0] q[$];
  logic        ready_low, acc, oacc, stalled_prev;
  int          sent, ecnt, cyc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef PARTIAL_FLUSH_EN
    in_last = 1'b0;
`endif
    // Reset state
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single vector 0x0..0xF
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(4'(i));
      if (i == 14) check("t1_no_early_valid", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", out_data, 64'hFEDCBA9876543210);
    check("t1_count", 64'(out_count), 64'd16);
    tick();
    check("t1_drop", 64'(out_valid), 64'd0);

    // 64 back-to-back elements
    ready_low = 1'b0; pattern = '0; exp_vec = '0;
    for (int i = 0; i < 64; i++) begin
      logic [3:0] d;
      d = 4'((i * 5 + i / 16) & 15);
      in_valid = 1'b1; in_data = d;
      #1;
      if (in_ready !== 1'b1) ready_low = 1'b1;
      exp_vec[(i % 16) * 4 +: 4] = d;
      tick();
      pattern[i] = out_valid;
      if ((i % 16) == 15) check("t2_vec", out_data, exp_vec);
    end
    in_valid = 1'b0;
    check("t2_valid_pattern", pattern, 64'h8000_8000_8000_8000);
    check("t2_ready_never_low", 64'(ready_low), 64'd0);
    tick();
    check("t2_drain", 64'(out_valid), 64'd0);

    // Output stalled: second vector parks in assembly register
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(4'(i));
    check("t3_v1_valid", 64'(out_valid), 64'd1);
    ready_low = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 4'(15 - i);
      #1;
      if (in_ready !== 1'b1) ready_low = 1'b1;
      tick();
    end
    check("t3_ready_during_v2", 64'(ready_low), 64'd0);
    check("t3_ready_parked", 64'(in_ready), 64'd0);
    check("t3_v1_held", out_data, 64'hFEDCBA9876543210);
    in_data = 4'h9;  // offered while not ready: must be ignored
    tick(); tick();
    in_valid = 1'b0;
    check("t3_v1_stable", out_data, 64'hFEDCBA9876543210);
    check("t3_valid_stable", 64'(out_valid), 64'd1);
    check("t3_ready_still_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("t3_v2_valid", 64'(out_valid), 64'd1);
    check("t3_v2_data", out_data, 64'h0123456789ABCDEF);
    check("t3_ready_back", 64'(in_ready), 64'd1);
    tick();
    check("t3_v2_drop", 64'(out_valid), 64'd0);
    for (int i = 0; i < 16; i++) send(4'h3);
    in_valid = 1'b0;
    check("t3_no_ignored_elem", out_data, 64'h3333333333333333);
    tick();

    // Reset mid-vector discards partial data
    for (int i = 0; i < 7; i++) send(4'hE);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t4_ready_in_rst", 64'(in_ready), 64'd0);
    tick();
    check("t4_valid_in_rst", 64'(out_valid), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) send(4'h1);
    in_valid = 1'b0;
    check("t4_data", out_data, 64'h1111111111111111);
    check("t4_count", 64'(out_count), 64'd16);
    tick();

`ifdef PARTIAL_FLUSH_EN
    for (int i = 0; i < 5; i++) begin
      in_last = (i == 4);
      send(4'hA);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("pf_valid", 64'(out_valid), 64'd1);
    check("pf_data", out_data, 64'h00000000000AAAAA);
    check("pf_count", 64'(out_count), 64'd5);
    tick();
`endif

    // Random traffic with scoreboard
    sent = 0; ecnt = 0; cyc = 0; cur = '0; stalled_prev = 1'b0; prev_data = '0;
    while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
      if (!in_valid && sent < 10000 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data  = 4'($urandom_range(0, 15));
      end
      out_ready = (sent >= 10000) ? 1'b1 : 1'($urandom_range(0, 1));
      #2;
      acc  = in_valid && in_ready;
      oacc = out_valid && out_ready;
      if (stalled_prev) begin
        check("rnd_stall_valid", 64'(out_valid), 64'd1);
        check("rnd_stall_data", out_data, prev_data);
      end
      if (oacc) begin
        if (q.size() == 0) check("rnd_unexpected_vec", out_data, 64'hx);
        else check("rnd_vec", out_data, q.pop_front());
      end
      if (acc) begin
        cur[ecnt * 4 +: 4] = in_data;
        ecnt++;
        sent++;
        if (ecnt == 16) begin
          q.push_back(cur);
          cur  = '0;
          ecnt = 0;
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_data    = out_data;
      tick();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    check("rnd_all_sent", 64'(sent), 64'd10000);
    check("rnd_queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
